// File: rtl/stoch_l2_norm_ctrl.sv
// rtl/stoch_l2_norm_ctrl.sv - evaluation sequencer for a stochastic L2-norm datapath
// Clears the datapath, lets it settle, then counts 1s on norm_y over a fixed window.
module stoch_l2_norm_ctrl #(
    parameter int VEC_LEN       = 2,
    parameter int WARMUP_CYCLES = 16,
    parameter int NUM_SAMPLES   = 256,
    parameter int CNT_WIDTH     = 9
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 start,
    input  logic                 abort,
    input  logic [VEC_LEN-1:0]   up_in,
    input  logic [VEC_LEN-1:0]   un_in,
    output logic [VEC_LEN-1:0]   norm_up,
    output logic [VEC_LEN-1:0]   norm_un,
    output logic                 norm_rst_n,
    input  logic                 norm_y,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int MAX_CYC = (WARMUP_CYCLES > NUM_SAMPLES) ? WARMUP_CYCLES : NUM_SAMPLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_CYCLES - 1);
    localparam logic [CW-1:0] SAMP_LAST = CW'(NUM_SAMPLES - 1);

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 norm_rst_n_q, norm_rst_n_d;
    logic [CNT_WIDTH-1:0] y_inc;
    logic                 gate;

    assign y_inc = {{(CNT_WIDTH-1){1'b0}}, norm_y};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE:   if (start && !abort) state_d = S_CLEAR;
            S_CLEAR:  state_d = abort ? S_IDLE : S_WARMUP;
            S_WARMUP: begin
                if (abort)                   state_d = S_IDLE;
                else if (cyc_q == WARM_LAST) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cyc_q == SAMP_LAST) begin
                    // Final window bit is folded in here so count is valid during DONE.
                    state_d = S_DONE;
                    count_d = acc_q + y_inc;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cyc_d = '0;
        if ((state_d == state_q) && ((state_q == S_WARMUP) || (state_q == S_SAMPLE)))
            cyc_d = cyc_q + 1'b1;
        acc_d = (state_q == S_SAMPLE) ? acc_q + y_inc : '0;
        busy_d       = (state_d == S_CLEAR) || (state_d == S_WARMUP) || (state_d == S_SAMPLE);
        done_d       = (state_d == S_DONE);
        norm_rst_n_d = (state_d != S_CLEAR);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            norm_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            norm_rst_n_q <= norm_rst_n_d;
        end
    end

    assign gate       = (state_q == S_WARMUP) || (state_q == S_SAMPLE);
    assign norm_up    = gate ? up_in : '0;
    assign norm_un    = gate ? un_in : '0;
    assign norm_rst_n = norm_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;

endmodule

// File: tb/tb_stoch_l2_norm_ctrl.sv
// tb/tb_stoch_l2_norm_ctrl.sv - randomized self-checking bench for stoch_l2_norm_ctrl
module tb_stoch_l2_norm_ctrl;

    localparam int VL = 2;
    localparam int W  = 16;
    localparam int N  = 256;
    localparam int CWD = 9;
    localparam int KDONE = W + N + 2;

    logic           CLK = 1'b0;
    logic           nRST = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [VL-1:0]  up_in = '0;
    logic [VL-1:0]  un_in = '0;
    logic [VL-1:0]  norm_up, norm_un;
    logic           norm_rst_n;
    logic           norm_y = 1'b0;
    logic           busy, done;
    logic [CWD-1:0] count;

    stoch_l2_norm_ctrl #(.VEC_LEN(VL), .WARMUP_CYCLES(W), .NUM_SAMPLES(N), .CNT_WIDTH(CWD)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .abort(abort),
        .up_in(up_in), .un_in(un_in), .norm_up(norm_up), .norm_un(norm_un),
        .norm_rst_n(norm_rst_n), .norm_y(norm_y), .busy(busy), .done(done), .count(count)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int ymode = 0;
    int rnd_ctrl = 0;

    // Reference: k is the number of cycles since start was accepted (0 = idle).
    int mk = 0;
    int msum = 0;
    int mcount = 0;
    bit rst_pend = 1'b1;
    int done_cycs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        bit gate;
        gate = (mk >= 2) && (mk <= W + N + 1);
        chk("busy", busy, (mk >= 1 && mk <= W + N + 1) ? 1 : 0);
        chk("done", done, (mk == KDONE) ? 1 : 0);
        chk("norm_rst_n", norm_rst_n, (rst_pend || mk == 1) ? 0 : 1);
        chk("norm_up", norm_up, gate ? up_in : 0);
        chk("norm_un", norm_un, gate ? un_in : 0);
        chk("count", count, mcount);
        if (done === 1'b1) done_cycs.push_back(cyc);
    endtask

    task automatic model_edge();
        if (!nRST) begin
            mk = 0; msum = 0; mcount = 0; rst_pend = 1'b1;
        end else begin
            rst_pend = 1'b0;
            if (mk == 0) begin
                if (start && !abort) begin mk = 1; msum = 0; end
            end else if (mk == KDONE) begin
                mk = 0;
            end else if (abort) begin
                mk = 0;
            end else begin
                if (mk >= W + 2 && norm_y) msum++;
                mk++;
                if (mk == KDONE) mcount = msum;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        compare();
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic drive();
        up_in = VL'($urandom);
        un_in = VL'($urandom);
        case (ymode)
            1: norm_y = 1'b1;
            2: norm_y = (mk >= 2 && mk <= W + 1);
            3: norm_y = cyc[0];
            default: norm_y = 1'(($urandom));
        endcase
        if (rnd_ctrl != 0) begin
            start = ($urandom_range(0, 40) == 0);
            abort = ($urandom_range(0, 300) == 0);
        end
        step();
    endtask

    task automatic run_to_idle(input string name);
        int b;
        b = 0;
        while (mk != 0 && b < 400) begin drive(); b++; end
        if (b >= 400) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic one_run(input int mode, input string name, input int exp_cnt);
        int ts;
        ymode = mode;
        start = 1'b1;
        ts = cyc;
        drive();
        start = 1'b0;
        done_cycs.delete();
        run_to_idle(name);
        chk({name, "_count"}, count, exp_cnt);
        chk({name, "_ndone"}, done_cycs.size(), 1);
        if (done_cycs.size() > 0) chk({name, "_latency"}, done_cycs[0] - ts, 274);
    endtask

    initial begin
        #1;
        repeat (3) drive();
        chk("rst_count", count, 0);
        chk("rst_norm_rst_n", norm_rst_n, 0);
        chk("rst_busy", busy, 0);
        nRST = 1'b1;
        repeat (3) drive();
        chk("post_rst_norm_rst_n", norm_rst_n, 1);

        // Constant-1 run, including the CLEAR-cycle datapath reset.
        ymode = 1;
        start = 1'b1;
        drive();
        start = 1'b0;
        #1;
        chk("clear_norm_rst_n", norm_rst_n, 0);
        chk("clear_busy", busy, 1);
        run_to_idle("ones");
        chk("ones_count", count, 256);

        // Gating: blocked in IDLE, transparent in WARMUP.
        up_in = 2'b11;
        #1;
        chk("gate_idle", norm_up, 0);
        start = 1'b1; drive(); start = 1'b0;
        drive();
        up_in = 2'b11;
        #1;
        chk("gate_warmup", norm_up, 3);
        step();
        run_to_idle("gate");

        one_run(2, "warm_only", 0);
        one_run(3, "alt", 128);
        one_run(1, "ones2", 256);

        // Abort in SAMPLE cycle 100 of a second run.
        ymode = 0;
        start = 1'b1; drive(); start = 1'b0;
        while (mk != W + 1 + 100) drive();
        abort = 1'b1; drive(); abort = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_count", count, 256);
        done_cycs.delete();
        repeat (300) drive();
        chk("abort_no_done", done_cycs.size(), 0);

        // start held for 1000 cycles.
        start = 1'b1;
        done_cycs.delete();
        repeat (1000) drive();
        start = 1'b0;
        chk("held_ndone", done_cycs.size(), 3);
        for (int i = 1; i < done_cycs.size(); i++)
            chk("held_period", done_cycs[i] - done_cycs[i-1], 275);
        run_to_idle("held");

        // Random start/abort traffic.
        rnd_ctrl = 1;
        repeat (2500) drive();
        rnd_ctrl = 0;
        start = 1'b0; abort = 1'b0;
        run_to_idle("rand");

        // Asynchronous reset in SAMPLE cycle 50.
        ymode = 1;
        start = 1'b1; drive(); start = 1'b0;
        while (mk != W + 1 + 50) drive();
        up_in = 2'b11;
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_norm_rst_n", norm_rst_n, 0);
        chk("arst_norm_up", norm_up, 0);
        chk("arst_count", count, 0);
        mk = 0; msum = 0; mcount = 0; rst_pend = 1'b1;
        @(posedge CLK); model_edge(); cyc++; #1;
        drive();
        nRST = 1'b1;
        done_cycs.delete();
        repeat (300) drive();
        chk("arst_after_busy", busy, 0);
        chk("arst_after_count", count, 0);
        chk("arst_after_done", done_cycs.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
